// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: prefetching instruction fetcher with a 2-entry buffer, redirect flush and halt drain.
module instr_fetch_unit #(
  parameter logic [7:0] BOOT_ADDR = 8'h00,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic [7:0]  cmd_addr,
  output logic        cmd_rd,
  input  logic [23:0] cmd,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [23:0] instr,
  output logic [7:0]  instr_pc,
  output logic        halted
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALT} state_t;
  localparam logic [1:0] CAP = 2'(DEPTH);
  state_t state;
  logic [7:0] pc, issue_pc;
  logic [1:0] count, count_nxt;
  logic [31:0] fifo [2];
  logic redirect, push, pop, issue, wr_idx;
  assign instr_valid = count != 2'd0;
  assign instr = fifo[0][23:0];
  assign instr_pc = fifo[0][31:24];
  assign halted = state == HALT;
  // cmd_rd doubles as the in-flight flag: its data is on cmd this cycle
  always_comb begin
    redirect = redirect_valid & (state == FETCH || state == DRAIN);
    pop = instr_valid & instr_ready & ~redirect;
    push = cmd_rd & ~redirect;
    count_nxt = redirect ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
    issue = state == IDLE ? start : state == FETCH && !halt_req && count_nxt < CAP;
    issue_pc = state == IDLE ? BOOT_ADDR : redirect ? redirect_pc : pc;
    wr_idx = count[0] ^ pop;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= BOOT_ADDR;
      count <= 2'd0;
      cmd_rd <= 1'b0;
      cmd_addr <= 8'h00;
      fifo[0] <= 32'h0;
      fifo[1] <= 32'h0;
    end else begin
      state <= state == IDLE && start ? FETCH :
               state == FETCH && halt_req ? DRAIN :
               state == DRAIN && count_nxt == 2'd0 ? HALT : state;
      cmd_rd <= issue;
      count <= count_nxt;
      if (issue) begin
        cmd_addr <= issue_pc;
        pc <= issue_pc + 8'd1;
      end else if (redirect) pc <= redirect_pc;
      if (pop) fifo[0] <= fifo[1];
      if (push) fifo[wr_idx] <= {cmd_addr, cmd};
    end
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter BOOT_ADDR, default 8'h00, meaning the PC loaded on start.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the instruction buffer entries (fixed 2; other values unsupported).
REQ-003 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  pulse; leave IDLE and begin fetching at BOOT_ADDR.
- halt_req  input  1  stop issuing new reads; enter HALT when drained.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  8  new fetch address when redirect_valid=1.
- cmd_addr  output  8  address to program memory, registered.
- cmd_rd  output  1  high when cmd_addr is a real fetch this cycle.
- cmd  input  24  program memory data, valid one cycle after cmd_addr/cmd_rd.
- instr_valid  output  1  instr/instr_pc hold a valid instruction.
- instr_ready  input  1  decoder accepts; transfer when valid & ready.
- instr  output  24  fetched instruction word.
- instr_pc  output  8  address instr was fetched from.
- halted  output  1  high in HALT state.

Function
REQ-004 FSM states SHALL be IDLE, FETCH, DRAIN, HALT; reset state IDLE.
REQ-005 IDLE -> FETCH on start=1; PC <= BOOT_ADDR; start ignored in other states.
REQ-006 FETCH -> DRAIN on halt_req=1 (no redirect same cycle); DRAIN -> HALT when buffer empty and no read in flight; HALT exits only via rst.
REQ-007 Memory read latency SHALL be exactly 1 cycle: data for a read issued in cycle N is captured from cmd at end of cycle N+1.
REQ-008 cmd_rd SHALL be 1 in FETCH only when (buffer occupancy + reads in flight) < 2 after counting a same-cycle pop; otherwise 0.
REQ-009 Each issued read SHALL present cmd_addr=PC, then PC <= PC+1 modulo 256 (8'hFF wraps to 8'h00).
REQ-010 Returned words SHALL be written to a 2-entry FIFO with their fetch PC; FIFO never overflows by construction of REQ-008.
REQ-011 instr_valid SHALL equal FIFO non-empty; instr/instr_pc SHALL show the head entry; pop on instr_valid & instr_ready.
REQ-012 Simultaneous push and pop SHALL keep occupancy unchanged and preserve order.
REQ-013 Steady state with instr_ready held 1 SHALL deliver one instruction per cycle; first instr_valid 2 cycles after the start cycle.
REQ-014 redirect_valid=1 (FETCH or DRAIN) SHALL flush the FIFO, discard any in-flight read data, and set PC <= redirect_pc; a handshake in the same cycle is void (not counted as a transfer).
REQ-015 The first read after redirect SHALL issue the cycle after redirect at redirect_pc; in DRAIN, redirect flushes but issues no read.
REQ-016 redirect_valid in IDLE or HALT SHALL be ignored.
REQ-017 halt_req and redirect_valid in the same FETCH cycle: redirect applied, then transition to DRAIN.
REQ-018 halted SHALL be 1 only in HALT; cmd_rd=0 and instr_valid=0 in IDLE and HALT.

Reset
REQ-019 rst=1 at any clock edge SHALL, mid-operation included, force IDLE, PC=BOOT_ADDR, FIFO empty, in-flight flag 0.
REQ-020 During and after reset: cmd_addr=8'h00, cmd_rd=0, instr_valid=0, instr=24'h0, instr_pc=8'h00, halted=0.

Verification
REQ-021 Reset, start, instr_ready=1, memory word=addr*3 -> instr_pc 0,1,2,3 on consecutive cycles, instr 0,3,6,9, first valid 2 cycles after start.
REQ-022 instr_ready=0 for 5 cycles during FETCH -> exactly 2 entries buffered, cmd_rd=0, no loss; on release PCs continue in order without gap.
REQ-023 Start with BOOT_ADDR=8'hFE, ready=1 -> instr_pc sequence FE, FF, 00, 01.
REQ-024 Redirect to 8'h40 while 2 entries buffered and a read in flight -> instr_valid drops next cycle; next delivered instr_pc=8'h40, stale words never appear.
REQ-025 halt_req with 1 entry buffered, ready=0 for 3 cycles then 1 -> halted stays 0 until entry popped, then halted=1 with cmd_rd=0.
REQ-026 rst asserted mid-stream with instr_valid=1 -> next cycle all outputs at REQ-020 values; start ignored until IDLE re-entered (immediately).
